// File: rtl/approx_mult_seq.sv
// approx_mult_seq: sequential approximate unsigned multiplier.
// Each operand is shifted left until its MSB is set. The top TRUNC bits of
// the two normalised operands are multiplied. The product is then shifted
// right by the combined normalisation shift. A zero operand skips the
// datapath, and the result register holds its value between operations.
module approx_mult_seq #(
    parameter int WIDTH = 16,
    parameter int TRUNC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(2*WIDTH);
    localparam int PW = 2*TRUNC;
    localparam int RW = 2*WIDTH;

    typedef enum logic [2:0] {IDLE, NORM, MULT, DENORM, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] ra_reg, ra_next;
    logic [WIDTH-1:0] rb_reg, rb_next;
    logic [SW-1:0]    sa_reg, sa_next;
    logic [SW-1:0]    sb_reg, sb_next;
    logic [RW-1:0]    sr_reg, sr_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [RW-1:0]    result_reg, result_next;
    logic [PW-1:0]    prod;

    // Product of the kept MSB slices of both normalised operands
    assign prod = PW'(ra_reg[WIDTH-1 -: TRUNC]) * PW'(rb_reg[WIDTH-1 -: TRUNC]);

    assign result = result_reg;

    // State and datapath registers; an active-low reset aborts any operation
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            ra_reg     <= '0;
            rb_reg     <= '0;
            sa_reg     <= '0;
            sb_reg     <= '0;
            sr_reg     <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ra_reg     <= ra_next;
            rb_reg     <= rb_next;
            sa_reg     <= sa_next;
            sb_reg     <= sb_next;
            sr_reg     <= sr_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
        end
    end

    // Next-state, datapath updates and status outputs
    always_comb begin
        state_next  = state_reg;
        ra_next     = ra_reg;
        rb_next     = rb_reg;
        sa_next     = sa_reg;
        sb_next     = sb_reg;
        sr_next     = sr_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        busy        = (state_reg != IDLE);
        done        = (state_reg == DONE);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    ra_next = a_in;
                    rb_next = b_in;
                    sa_next = '0;
                    sb_next = '0;
                    if (a_in == '0 || b_in == '0) begin
                        // A zero operand gives an exact zero product.
                        result_next = '0;
                        state_next  = DONE;
                    end else begin
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                if (ra_reg[WIDTH-1] && rb_reg[WIDTH-1]) begin
                    state_next = MULT;
                end else begin
                    // Each operand shifts on its own until its MSB is set.
                    if (!ra_reg[WIDTH-1]) begin
                        ra_next = {ra_reg[WIDTH-2:0], 1'b0};
                        sa_next = sa_reg + 1'b1;
                    end
                    if (!rb_reg[WIDTH-1]) begin
                        rb_next = {rb_reg[WIDTH-2:0], 1'b0};
                        sb_next = sb_reg + 1'b1;
                    end
                end
            end
            MULT: begin
                sr_next    = RW'(prod) << (RW - PW);
                cnt_next   = CW'(sa_reg) + CW'(sb_reg);
                state_next = DENORM;
            end
            DENORM: begin
                if (cnt_reg == '0) begin
                    result_next = sr_reg;
                    state_next  = DONE;
                end else begin
                    sr_next  = sr_reg >> 1;
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_approx_mult_seq.sv
// Testbench for approx_mult_seq. It drives a 16/8 instance and an 8/4
// instance and compares them against an arithmetic model of the
// normalise-truncate-denormalise formula.
module tb_approx_mult_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] res16;
    logic        s8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    int checks = 0;
    int errors = 0;

    approx_mult_seq #(.WIDTH(16), .TRUNC(8)) dut16 (
        .clk(clk), .rst(rst), .start(s16), .a_in(a16), .b_in(b16),
        .busy(busy16), .done(done16), .result(res16)
    );

    approx_mult_seq #(.WIDTH(8), .TRUNC(4)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .result(res8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic model: count leading zeros by magnitude and multiply the kept MSBs.
    function automatic logic [63:0] ref_model(input int w, input int t,
                                              input logic [63:0] a, input logic [63:0] b,
                                              output int lat);
        logic [63:0] na, nb, p;
        int sa, sb;
        lat = 0;
        if (a == 0 || b == 0) return 64'd0;
        na = a; nb = b; sa = 0; sb = 0;
        while (na < (64'd1 << (w-1))) begin na = na * 2; sa++; end
        while (nb < (64'd1 << (w-1))) begin nb = nb * 2; sb++; end
        p   = (na >> (w-t)) * (nb >> (w-t));
        lat = 3 + ((sa > sb) ? sa : sb) + sa + sb;
        return (p << (2*w - 2*t)) >> (sa + sb);
    endfunction

    task automatic run16(input logic [15:0] a, input logic [15:0] b, output logic [63:0] obs);
        logic [63:0] exp, prev;
        int lat, got;
        exp = ref_model(16, 8, {48'd0, a}, {48'd0, b}, lat);
        @(negedge clk);
        a16 = a; b16 = b; s16 = 1'b1;
        prev = {32'd0, res16};
        @(posedge clk);
        @(negedge clk);
        s16 = 1'b0;
        got = -1;
        for (int m = 0; m <= 200; m++) begin
            if (m > 0) @(negedge clk);
            if (done16) begin got = m; break; end
            check("busy16_run", {63'd0, busy16}, 64'd1);
            check("hold16", {32'd0, res16}, prev);
        end
        obs = {32'd0, res16};
        $display("op16 a=%04h b=%04h result=%08h latency=%0d (model %08h / %0d)",
                 a, b, res16, got, exp, lat);
        check("lat16", 64'(got), 64'(lat));
        check("res16", obs, exp);
        check("busy16_done", {63'd0, busy16}, 64'd1);
        @(negedge clk);
        check("pulse16", {63'd0, done16}, 64'd0);
        check("idle16", {63'd0, busy16}, 64'd0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, output logic [63:0] obs);
        logic [63:0] exp;
        int lat, got;
        exp = ref_model(8, 4, {56'd0, a}, {56'd0, b}, lat);
        @(negedge clk);
        a8 = a; b8 = b; s8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s8 = 1'b0;
        got = -1;
        for (int m = 0; m <= 100; m++) begin
            if (m > 0) @(negedge clk);
            if (done8) begin got = m; break; end
        end
        obs = {48'd0, res8};
        $display("op8 a=%02h b=%02h result=%04h latency=%0d (model %04h / %0d)",
                 a, b, res8, got, exp, lat);
        check("lat8", 64'(got), 64'(lat));
        check("res8", obs, exp);
        @(negedge clk);
        check("pulse8", {63'd0, done8}, 64'd0);
    endtask

    initial begin
        logic [63:0] obs;
        logic [63:0] exp;
        logic [7:0]  ra8, rb8;
        logic [15:0] ra16, rb16;
        int lat, got, pulses;

        rst = 1'b0; s16 = 1'b0; s8 = 1'b0;
        a16 = '0; b16 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        $display("reset state busy16=%0b done16=%0b res16=%08h busy8=%0b res8=%04h",
                 busy16, done16, res16, busy8, res8);
        check("rst_busy16", {63'd0, busy16}, 64'd0);
        check("rst_done16", {63'd0, done16}, 64'd0);
        check("rst_res16", {32'd0, res16}, 64'd0);
        check("rst_busy8", {63'd0, busy8}, 64'd0);
        check("rst_res8", {48'd0, res8}, 64'd0);
        rst = 1'b1;

        // Directed cases with hand-derived constants
        run16(16'h8000, 16'h8000, obs);
        check("tp_8000", obs, 64'h40000000);
        run16(16'h0003, 16'h0005, obs);
        check("tp_3x5", obs, 64'd15);
        run16(16'h01FF, 16'h0003, obs);
        check("tp_1ffx3", obs, 64'h5FA);
        run16(16'h0000, 16'h1234, obs);
        check("tp_zero_a", obs, 64'd0);
        run16(16'h1234, 16'h0000, obs);
        check("tp_zero_b", obs, 64'd0);
        run16(16'h0001, 16'h0001, obs);
        check("tp_worst", obs, 64'd1);
        run8(8'hFF, 8'hFF, obs);
        check("tp_ff8", obs, 64'hE100);

        // start held high through DONE relaunches after one IDLE cycle
        exp = ref_model(16, 8, 64'h0123, 64'h0456, lat);
        @(negedge clk);
        a16 = 16'h0123; b16 = 16'h0456; s16 = 1'b1;
        got = -1;
        for (int m = 0; m <= 200; m++) begin
            @(negedge clk);
            if (done16) begin got = m; break; end
        end
        check("held_first_done", 64'(got >= 0), 64'd1);
        @(negedge clk);
        check("held_gap", {63'd0, busy16}, 64'd0);
        @(negedge clk);
        check("held_relaunch", {63'd0, busy16}, 64'd1);
        s16 = 1'b0;
        got = -1;
        for (int m = 1; m <= 200; m++) begin
            @(negedge clk);
            if (done16) begin got = m; break; end
        end
        $display("held start relaunch result=%08h latency=%0d (model %08h / %0d)", res16, got, exp, lat);
        check("held_lat", 64'(got), 64'(lat));
        check("held_res", {32'd0, res16}, exp);

        // Start during busy is ignored; reset mid-operation aborts it
        @(negedge clk);
        a16 = 16'h0003; b16 = 16'h0005; s16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s16 = 1'b0;
        repeat (4) @(negedge clk);
        a16 = 16'h7777; b16 = 16'h0101; s16 = 1'b1;
        @(negedge clk);
        s16 = 1'b0;
        check("ignored_start_busy", {63'd0, busy16}, 64'd1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        $display("after mid-op reset busy=%0b done=%0b result=%08h", busy16, done16, res16);
        check("abort_busy", {63'd0, busy16}, 64'd0);
        check("abort_done", {63'd0, done16}, 64'd0);
        check("abort_res", {32'd0, res16}, 64'd0);
        pulses = 0;
        for (int m = 0; m < 60; m++) begin
            @(negedge clk);
            if (done16) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);

        // Randomised sweeps against the model
        for (int i = 0; i < 40; i++) begin
            ra8 = 8'($urandom_range(0, 255));
            rb8 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) ra8 = 8'd0;
            if ($urandom_range(0, 9) == 0) rb8 = 8'd0;
            run8(ra8, rb8, obs);
        end
        for (int i = 0; i < 12; i++) begin
            ra16 = 16'($urandom_range(1, 65535) >> $urandom_range(0, 12));
            rb16 = 16'($urandom_range(1, 65535) >> $urandom_range(0, 12));
            run16(ra16, rb16, obs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/approx_mult_seq.md
# approx_mult_seq

Parametrised sequential approximate multiplier with its own controller and start/done handshake. Each unsigned operand is normalised by left-shifting to its leading one. The top TRUNC bits of both normalised operands are multiplied. The product is then right-shifted back by the total shift count. It replaces the hand-wired fixed 16-bit datapath plus external controller, and adds generic widths, zero-operand bypass, busy/done signalling and a held result register.

## Interface
- WIDTH, 16: operand width in bits; legal range 4..32.
- TRUNC, 8: number of kept MSBs after normalisation; legal range 2..WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  in  1  request; sampled only in IDLE.
- a_in  in  WIDTH  operand A, unsigned; captured on the accepted start edge.
- b_in  in  WIDTH  operand B, unsigned; captured on the accepted start edge.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; high in state DONE.
- result  out  2*WIDTH  approximate product; updated only when entering DONE, held otherwise.

## Operation
- States: IDLE, NORM, MULT, DENORM, DONE.
- IDLE, start=1:
  - Capture a_in and b_in into regs ra and rb.
  - Clear shift counters sa and sb, each clog2(WIDTH) bits wide.
  - If a_in==0 or b_in==0, go to DONE with result loaded 0 (zero bypass). Otherwise go to NORM.
- NORM:
  - If ra[WIDTH-1]==1 and rb[WIDTH-1]==1, go to MULT.
  - Otherwise, in the same cycle, left-shift each register whose MSB is 0 by one bit (zero fill) and increment its counter.
  - The two operands shift independently; an operand whose MSB is already 1 holds.
- MULT:
  - P = ra[WIDTH-1:WIDTH-TRUNC] * rb[WIDTH-1:WIDTH-TRUNC], width 2*TRUNC.
  - Load shift reg sr = {P, (2*WIDTH-2*TRUNC) zeros}.
  - Load cnt = sa + sb, width clog2(2*WIDTH).
  - Go to DENORM.
- DENORM:
  - If cnt==0, result <= sr and go to DONE.
  - Otherwise logical right shift sr by 1 and decrement cnt.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Arithmetic: result = ({P, zeros}) >> (sa+sb).
  - Exact whenever neither operand has any 1 below its top TRUNC normalised bits; otherwise it truncates toward zero.
- start while busy=1 is ignored and is not queued.
- start held high through DONE launches a new operation from IDLE on the following cycle; back-to-back issue has a 1-cycle IDLE gap.

## Timing
- Reset (rst=0 at a clk edge):
  - State goes to IDLE; busy=0, done=0, result=0; all internal regs are cleared.
  - Applies mid-operation; the operation is aborted and no done pulse is produced.
- Let k be the accepted start edge. For non-zero operands, done is high in the cycle after edge k+3+max(sa,sb)+sa+sb.
  - Cycle counts: NORM lasts max(sa,sb)+1 cycles, MULT 1 cycle, DENORM sa+sb+1 cycles.
- Zero bypass: done is high in the cycle after edge k (1-cycle latency).
- Worst case is a_in=b_in=1: sa=sb=WIDTH-1, giving 3*WIDTH latency cycles.
- result changes only on the edge entering DONE; it is stable at all other times, including while busy.

## Test plan
- Defaults, a_in=0x8000, b_in=0x8000 -> result=0x40000000; done pulses once, 3 cycles after the start edge.
- a_in=0x0003, b_in=0x0005 -> sa=14, sb=13, result=15 (exact); done at 3+14+27=44 cycles.
- a_in=0x01FF, b_in=0x0003 -> result=0x5FA (1530, exact value 1533); done at 38 cycles.
- a_in=0x0000, b_in=0x1234 -> result=0, done 1 cycle after start; busy high for exactly 1 cycle. Repeat with b_in=0.
- Start the 0x0003*0x0005 case, pulse start again at cycle 5 with different operands, then assert rst=0 at cycle 10 -> the second start is ignored; after reset busy=0, done=0, result=0 and no done pulse appears.
- WIDTH=8, TRUNC=4, a_in=0xFF, b_in=0xFF -> P=0xE1, result=0xE100 (exact 0xFE01); sweep random operands against a reference model of the truncation formula.
